// File: rtl/compare_result_monitor.sv
// Debounced monitor for the one-hot comparator result xyz (x = A>B, y = A=B, z = A<B).
// Holds the accepted result as registered LEDs, pulses on change, counts transitions and flags illegal codes.
module compare_result_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             xyz_in,
  input  logic                   enable,
  input  logic                   clear,
  output logic                   led_gt,
  output logic                   led_eq,
  output logic                   led_lt,
  output logic                   changed,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] gt_count,
  output logic [COUNT_WIDTH-1:0] eq_count,
  output logic [COUNT_WIDTH-1:0] lt_count
);

  typedef enum logic [1:0] {
    NONE,
    GREATER,
    EQUAL,
    LESS
  } state_t;

  localparam logic [7:0]             STABLE_LIMIT = 8'(STABLE_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE    = COUNT_WIDTH'(1);

  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] candidate;
  logic [7:0] stable_count;
  logic       judged;
  logic       judge;
  logic       code_valid;
  logic       accept;
  state_t     state;
  state_t     decoded;

  // xyz_in comes straight from switches, so it is brought into the clock domain first
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 3'b000;
      s2 <= 3'b000;
    end else begin
      s1 <= xyz_in;
      s2 <= s1;
    end
  end

  // Any change of the synchronised code restarts the stable run; the count saturates at the limit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      candidate    <= 3'b000;
      stable_count <= 8'd0;
      judged       <= 1'b0;
    end else if (s2 != candidate) begin
      candidate    <= s2;
      stable_count <= 8'd1;
      judged       <= 1'b0;
    end else begin
      if (stable_count < STABLE_LIMIT) begin
        stable_count <= stable_count + 8'd1;
      end
      if (judge) begin
        judged <= 1'b1;
      end
    end
  end

  assign judge = (stable_count == STABLE_LIMIT) && !judged && enable;

  always_comb begin
    decoded    = NONE;
    code_valid = 1'b1;
    case (candidate)
      3'b100:  decoded = GREATER;
      3'b010:  decoded = EQUAL;
      3'b001:  decoded = LESS;
      default: code_valid = 1'b0;
    endcase
  end

  assign accept = judge && code_valid && (decoded != state);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= NONE;
      led_gt  <= 1'b0;
      led_eq  <= 1'b0;
      led_lt  <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (accept) begin
        state   <= decoded;
        led_gt  <= (decoded == GREATER);
        led_eq  <= (decoded == EQUAL);
        led_lt  <= (decoded == LESS);
        changed <= 1'b1;
      end
    end
  end

  // clear wins over a same-edge error set or counter increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (clear) begin
      error <= 1'b0;
    end else if (judge && !code_valid) begin
      error <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gt_count <= '0;
      eq_count <= '0;
      lt_count <= '0;
    end else if (clear) begin
      gt_count <= '0;
      eq_count <= '0;
      lt_count <= '0;
    end else if (accept) begin
      if (decoded == GREATER && gt_count != COUNT_MAX) begin
        gt_count <= gt_count + COUNT_ONE;
      end
      if (decoded == EQUAL && eq_count != COUNT_MAX) begin
        eq_count <= eq_count + COUNT_ONE;
      end
      if (decoded == LESS && lt_count != COUNT_MAX) begin
        lt_count <= lt_count + COUNT_ONE;
      end
    end
  end

endmodule
